// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, drives the instruction-memory address and
// loads the returned word plus PC+4 into the IF/ID register, honouring freeze and branch flush.
module if_stage #(
   parameter logic [31:0] RESET_PC  = 32'd0,
   parameter int          CNT_WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 freeze,
   input  logic                 branch_taken,
   input  logic [31:0]          branch_addr,
   output logic [31:0]          imem_addr,
   input  logic [31:0]          imem_rdata,
   output logic [31:0]          id_instr,
   output logic [31:0]          id_pc,
   output logic                 id_valid,
   output logic [CNT_WIDTH-1:0] fetch_count
);

   localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

   logic [31:0]          pc_q, pc_d;
   logic [31:0]          instr_q, instr_d;
   logic [31:0]          idpc_q, idpc_d;
   logic                 valid_q, valid_d;
   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
   logic [31:0]          pc_plus4;

   assign pc_plus4  = pc_q + 32'd4;
   assign imem_addr = pc_q;

   // Branch outranks freeze: a taken branch always redirects and flushes.
   always_comb begin
      pc_d    = pc_q;
      instr_d = instr_q;
      idpc_d  = idpc_q;
      valid_d = valid_q;
      cnt_d   = cnt_q;
      if (branch_taken) begin
         pc_d    = {branch_addr[31:2], 2'b00};
         instr_d = 32'd0;
         idpc_d  = 32'd0;
         valid_d = 1'b0;
      end else if (!freeze) begin
         pc_d    = pc_plus4;
         instr_d = imem_rdata;
         idpc_d  = pc_plus4;
         valid_d = 1'b1;
         if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_ONE;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pc_q    <= RESET_PC;
         instr_q <= 32'd0;
         idpc_q  <= 32'd0;
         valid_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         pc_q    <= pc_d;
         instr_q <= instr_d;
         idpc_q  <= idpc_d;
         valid_q <= valid_d;
         cnt_q   <= cnt_d;
      end
   end

   assign id_instr    = instr_q;
   assign id_pc       = idpc_q;
   assign id_valid    = valid_q;
   assign fetch_count = cnt_q;

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: a behavioural fetch model queues the expected state per edge,
// plus directed checks on boundary instances (wrapping reset PC, 4-bit counter).
module tb_if_stage;

   logic        clk;
   logic        rst_n;
   logic        freeze;
   logic        branch_taken;
   logic [31:0] branch_addr;
   logic [31:0] imem_addr, imem_rdata, id_instr, id_pc;
   logic        id_valid;
   logic [31:0] fetch_count;

   logic        tie0;
   logic [31:0] tie0_32;
   logic [31:0] b_addr, b_rdata, b_instr, b_pc, b_cnt;
   logic        b_valid;
   logic [31:0] c_addr, c_rdata, c_instr, c_pc;
   logic        c_valid;
   logic [3:0]  c_cnt;

   int n_chk  = 0;
   int n_pass = 0;

   function automatic logic [31:0] rom(input logic [31:0] a);
      case (a)
         32'd0:   rom = 32'hE3A00014;
         32'd4:   rom = 32'hE3A01001;
         32'd8:   rom = 32'hE0802001;
         32'd12:  rom = 32'hE2511001;
         32'd16:  rom = 32'h00000000;
         default: rom = 32'hE1A00000 ^ a;
      endcase
   endfunction

   assign imem_rdata = rom(imem_addr);
   assign b_rdata    = rom(b_addr);
   assign c_rdata    = rom(c_addr);

   if_stage dut (
      .clk(clk), .rst_n(rst_n), .freeze(freeze), .branch_taken(branch_taken),
      .branch_addr(branch_addr), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
      .id_instr(id_instr), .id_pc(id_pc), .id_valid(id_valid), .fetch_count(fetch_count)
   );

   if_stage #(.RESET_PC(32'hFFFFFFF8)) dut_wrap (
      .clk(clk), .rst_n(rst_n), .freeze(tie0), .branch_taken(tie0),
      .branch_addr(tie0_32), .imem_addr(b_addr), .imem_rdata(b_rdata),
      .id_instr(b_instr), .id_pc(b_pc), .id_valid(b_valid), .fetch_count(b_cnt)
   );

   if_stage #(.CNT_WIDTH(4)) dut_sat (
      .clk(clk), .rst_n(rst_n), .freeze(tie0), .branch_taken(tie0),
      .branch_addr(tie0_32), .imem_addr(c_addr), .imem_rdata(c_rdata),
      .id_instr(c_instr), .id_pc(c_pc), .id_valid(c_valid), .fetch_count(c_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
      logic [31:0] idpc;
      logic        valid;
      logic [31:0] cnt;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] m_pc, m_instr, m_idpc, m_cnt;
   logic        m_valid;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%h expected=%h (t=%0t)", tag, got, exp, $time);
   endtask

   // Drive one edge's inputs, queue the model's post-edge state, then compare after the edge.
   task automatic step(input logic rst, input logic frz, input logic br, input logic [31:0] ba);
      exp_t e;
      @(negedge clk);
      rst_n = rst; freeze = frz; branch_taken = br; branch_addr = ba;
      if (!rst) begin
         m_pc = 32'd0; m_instr = 32'd0; m_idpc = 32'd0; m_valid = 1'b0; m_cnt = 32'd0;
      end else if (br) begin
         m_pc = {ba[31:2], 2'b00}; m_instr = 32'd0; m_idpc = 32'd0; m_valid = 1'b0;
      end else if (!frz) begin
         m_instr = rom(m_pc); m_idpc = m_pc + 32'd4; m_valid = 1'b1;
         if (m_cnt != 32'hFFFFFFFF) m_cnt = m_cnt + 32'd1;
         m_pc = m_pc + 32'd4;
      end
      e.pc = m_pc; e.instr = m_instr; e.idpc = m_idpc; e.valid = m_valid; e.cnt = m_cnt;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      chk("imem_addr", imem_addr, e.pc);
      chk("id_instr", id_instr, e.instr);
      chk("id_pc", id_pc, e.idpc);
      chk("id_valid", {31'd0, id_valid}, {31'd0, e.valid});
      chk("fetch_count", fetch_count, e.cnt);
   endtask

   initial begin
      tie0 = 1'b0; tie0_32 = 32'd0;
      rst_n = 1'b0; freeze = 1'b0; branch_taken = 1'b0; branch_addr = 32'd0;
      m_pc = 32'd0; m_instr = 32'd0; m_idpc = 32'd0; m_valid = 1'b0; m_cnt = 32'd0;

      step(1'b0, 1'b0, 1'b0, 32'd0);
      step(1'b0, 1'b0, 1'b0, 32'd0);
      chk("rst_wrap_pc", b_addr, 32'hFFFFFFF8);
      chk("rst_sat_cnt", {28'd0, c_cnt}, 32'd0);

      step(1'b1, 1'b0, 1'b0, 32'd0);
      chk("e1_instr", id_instr, 32'hE3A00014);
      chk("e1_idpc", id_pc, 32'd4);
      chk("e1_addr", imem_addr, 32'd4);
      chk("wrap_pc_e1", b_addr, 32'hFFFFFFFC);
      step(1'b1, 1'b0, 1'b0, 32'd0);
      chk("wrap_pc_e2", b_addr, 32'h00000000);
      chk("wrap_idpc", b_pc, 32'h00000000);
      chk("wrap_instr", b_instr, rom(32'hFFFFFFFC));
      step(1'b1, 1'b0, 1'b0, 32'd0);
      chk("e3_instr", id_instr, 32'hE0802001);
      chk("e3_idpc", id_pc, 32'd12);
      chk("e3_cnt", fetch_count, 32'd3);

      step(1'b1, 1'b0, 1'b0, 32'd0);
      step(1'b1, 1'b0, 1'b0, 32'd0);
      chk("zero_word_valid", {31'd0, id_valid}, 32'd1);
      chk("zero_word_instr", id_instr, 32'd0);
      chk("pc_before_freeze", imem_addr, 32'd20);

      for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 32'd0);
      chk("frz_pc", imem_addr, 32'd20);
      chk("frz_idpc", id_pc, 32'd20);
      chk("frz_cnt", fetch_count, 32'd5);
      step(1'b1, 1'b0, 1'b0, 32'd0);
      chk("rel_instr", id_instr, rom(32'd20));
      chk("rel_idpc", id_pc, 32'd24);

      for (int i = 0; i < 31; i++) begin
         step(1'b1, 1'b0, 1'b0, 32'd0);
         if (i == 4) chk("sat_cnt_14", {28'd0, c_cnt}, 32'd14);
         if (i == 5) chk("sat_cnt_15", {28'd0, c_cnt}, 32'd15);
      end
      chk("sat_cnt_hold", {28'd0, c_cnt}, 32'd15);
      chk("pc_148_a", imem_addr, 32'd148);

      step(1'b1, 1'b0, 1'b1, 32'd112);
      chk("br112_pc", imem_addr, 32'd112);
      chk("br112_valid", {31'd0, id_valid}, 32'd0);
      chk("br112_cnt", fetch_count, 32'd37);
      step(1'b1, 1'b0, 1'b0, 32'd0);
      chk("br112_instr", id_instr, rom(32'd112));
      chk("br112_idpc", id_pc, 32'd116);

      for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b0, 32'd0);
      chk("pc_148_b", imem_addr, 32'd148);
      step(1'b1, 1'b0, 1'b1, 32'd115);
      chk("br115_pc", imem_addr, 32'd112);
      chk("br115_instr", id_instr, 32'd0);
      step(1'b1, 1'b0, 1'b0, 32'd0);
      chk("br115_instr2", id_instr, rom(32'd112));
      chk("br115_idpc", id_pc, 32'd116);

      step(1'b1, 1'b1, 1'b1, 32'd60);
      chk("brfrz_pc", imem_addr, 32'd60);
      chk("brfrz_valid", {31'd0, id_valid}, 32'd0);

      for (int i = 0; i < 9; i++) step(1'b1, 1'b0, 1'b0, 32'd0);
      chk("pc_96", imem_addr, 32'd96);
      step(1'b0, 1'b1, 1'b1, 32'd200);
      chk("mrst_addr", imem_addr, 32'd0);
      chk("mrst_valid", {31'd0, id_valid}, 32'd0);
      chk("mrst_cnt", fetch_count, 32'd0);
      step(1'b1, 1'b0, 1'b0, 32'd0);
      chk("resume_instr", id_instr, 32'hE3A00014);
      chk("resume_cnt", fetch_count, 32'd1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
